arb_mux: RTL and testbench



---
 rtl/arb_mux_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/arb_mux.sv | 120 ++++++++++++
 tb/tb_arb_mux.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrated output multiplexer.
// Holds the arbitration policy type and a small index helper.
package arb_mux_pkg;

  // Arbitration policy: rotating priority or fixed lowest-index-wins.
  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  // Next channel index after idx, wrapping from n-1 back to 0.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pure combinational grant generator for arb_mux.
// Searches the request vector starting at ptr (round-robin) or at 0 (fixed)
// and returns a one-hot grant, its encoded index and an any-grant flag.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int        CHANNELS = 4,
  parameter arb_mode_t MODE     = ARB_RR,
  parameter int        IDX_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_any
);

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] cand;

  // Walk the channels from the start point, wrapping, and keep the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    start     = (MODE == ARB_FIXED) ? '0 : ptr;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = IDX_W'((int'(start) + i) % CHANNELS);
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Registered, arbitrated N-to-1 multiplexer with valid/ready handshakes.
// One requesting channel wins per cycle; its beat is captured in a single
// output stage together with its last flag and source index.
// Optional burst locking is enabled by defining ARB_MUX_LOCK_EN.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int        WIDTH    = 32,
  parameter int        CHANNELS = 4,
  parameter arb_mode_t MODE     = ARB_RR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   in_bus,
  input  logic [CHANNELS-1:0]         in_valid,
  input  logic [CHANNELS-1:0]         in_last,
  output logic [CHANNELS-1:0]         in_ready,
  output logic [WIDTH-1:0]            out,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [$clog2(CHANNELS)-1:0] out_sel,
  input  logic                        out_ready
);

  localparam int IDX_W = $clog2(CHANNELS);

  logic [IDX_W-1:0]    ptr;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_any;
  logic                load;
  logic                transfer;
  logic                ptr_advance;
  logic [WIDTH-1:0]    slices [CHANNELS];
  logic [WIDTH-1:0]    sel_data;
  logic                sel_last;

  // Channel 0 sits in the most-significant slice of the packed bus.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_slice
    assign slices[k] = in_bus[(CHANNELS-1-k)*WIDTH +: WIDTH];
  end

`ifdef ARB_MUX_LOCK_EN
  logic             lock_active;
  logic [IDX_W-1:0] lock_idx;

  // While a burst is open only the owning channel may compete.
  always_comb begin
    req = in_valid;
    if (lock_active) begin
      req           = '0;
      req[lock_idx] = in_valid[lock_idx];
    end
  end

  // The rotation pointer moves only when a burst completes.
  assign ptr_advance = sel_last;

  // Open the lock on a non-final beat, release it on the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active <= 1'b0;
      lock_idx    <= '0;
    end else if (transfer) begin
      lock_active <= ~sel_last;
      lock_idx    <= grant_idx;
    end
  end
`else
  assign req         = in_valid;
  assign ptr_advance = 1'b1;
`endif

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .MODE     (MODE),
    .IDX_W    (IDX_W)
  ) u_arbiter (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The output stage can accept a beat when empty or being drained this cycle.
  assign load     = ~out_valid | out_ready;
  assign in_ready = grant & {CHANNELS{load}};
  assign transfer = grant_any & load;
  assign sel_data = slices[grant_idx];
  assign sel_last = in_last[grant_idx];

  // Round-robin pointer moves just past the channel that was served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (MODE == ARB_RR && transfer && ptr_advance) begin
      ptr <= IDX_W'(next_index(int'(grant_idx), CHANNELS));
    end
  end

  // Single output register: load the winner, empty out, or hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= transfer;
      if (transfer) begin
        out      <= sel_data;
        out_last <= sel_last;
        out_sel  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: one round-robin and one fixed-priority
// instance share stimulus; a scoreboard queue holds the beat each accept
// should present on the output stage.
module tb_arb_mux;
  import arb_mux_pkg::*;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic [1:0]       sel;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [WIDTH-1:0]          data_w [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] in_bus;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_last;
  logic                      out_ready;

  logic [CHANNELS-1:0] rr_in_ready, fx_in_ready, obs_in_ready;
  logic [WIDTH-1:0]    rr_out, fx_out, obs_out;
  logic                rr_out_valid, fx_out_valid, obs_out_valid;
  logic                rr_out_last, fx_out_last, obs_out_last;
  logic [1:0]          rr_out_sel, fx_out_sel, obs_out_sel;
  logic                use_fixed;

  beat_t sb[$];
  logic  exp_out_valid;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  assign in_bus = {data_w[0], data_w[1], data_w[2], data_w[3]};

  assign obs_in_ready  = use_fixed ? fx_in_ready  : rr_in_ready;
  assign obs_out       = use_fixed ? fx_out       : rr_out;
  assign obs_out_valid = use_fixed ? fx_out_valid : rr_out_valid;
  assign obs_out_last  = use_fixed ? fx_out_last  : rr_out_last;
  assign obs_out_sel   = use_fixed ? fx_out_sel   : rr_out_sel;

  arb_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MODE(ARB_RR)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (rr_in_ready),
    .out       (rr_out),
    .out_valid (rr_out_valid),
    .out_last  (rr_out_last),
    .out_sel   (rr_out_sel),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MODE(ARB_FIXED)) u_fx (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (fx_in_ready),
    .out       (fx_out),
    .out_valid (fx_out_valid),
    .out_last  (fx_out_last),
    .out_sel   (fx_out_sel),
    .out_ready (out_ready)
  );

  // One counted comparison; a mismatch is reported and counted, the run continues.
  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the output stage against the head of the scoreboard.
  task automatic checkOutput(input string tag);
    checkValue({tag, ".out_valid"}, 32'(obs_out_valid), 32'(exp_out_valid));
    if (exp_out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s.scoreboard: observed empty expected one beat", tag);
      end else begin
        checkValue({tag, ".out"},      32'(obs_out),      32'(sb[0].data));
        checkValue({tag, ".out_sel"},  32'(obs_out_sel),  32'(sb[0].sel));
        checkValue({tag, ".out_last"}, 32'(obs_out_last), 32'(sb[0].last));
      end
    end
  endtask

  // Drive one cycle, check in_ready mid-cycle, update the scoreboard, check outputs after the edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic ordy,
                               input logic [3:0] exp_rdy, input string tag);
    logic       load;
    int         acc;
    logic [1:0] idx;
    beat_t      b;
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    @(negedge clk);
    checkValue({tag, ".in_ready"}, 32'(obs_in_ready), 32'(exp_rdy));
    load = !exp_out_valid || ordy;
    case (exp_rdy & v)
      4'b0001: acc = 0;
      4'b0010: acc = 1;
      4'b0100: acc = 2;
      4'b1000: acc = 3;
      default: acc = -1;
    endcase
    if (exp_out_valid && ordy && sb.size() > 0) void'(sb.pop_front());
    if (acc >= 0) begin
      idx    = acc[1:0];
      b.data = data_w[idx];
      b.last = l[idx];
      b.sel  = idx;
      sb.push_back(b);
    end
    if (load) exp_out_valid = (acc >= 0);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Hold reset for two edges and check every output returns to its idle value.
  task automatic doReset(input string tag);
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    sb.delete();
    exp_out_valid = 1'b0;
    checkValue({tag, ".out_valid"}, 32'(obs_out_valid), 32'd0);
    checkValue({tag, ".out_sel"},   32'(obs_out_sel),   32'd0);
    checkValue({tag, ".out"},       32'(obs_out),       32'd0);
    checkValue({tag, ".out_last"},  32'(obs_out_last),  32'd0);
    checkValue({tag, ".in_ready"},  32'(obs_in_ready),  32'd0);
    rst = 1'b0;
  endtask

  // Directed sequence of arbitration scenarios.
  initial begin
    use_fixed     = 1'b0;
    exp_out_valid = 1'b0;
    for (int k = 0; k < CHANNELS; k++) data_w[k] = 32'hA000_0000 + 32'(k);

    doReset("reset0");

    // All channels requesting: rotation 0,1,2,3,0
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0001, "rr_all0");
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0010, "rr_all1");
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0100, "rr_all2");
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b1000, "rr_all3");
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0001, "rr_all4");
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, "rr_drain");

    // Sparse requesters 1 and 3 from pointer 0, including the wrap
    doReset("reset1");
    applyStimulus(4'b1010, 4'b1111, 1'b1, 4'b0010, "sparse0");
    applyStimulus(4'b1010, 4'b1111, 1'b1, 4'b1000, "sparse1");
    applyStimulus(4'b1010, 4'b1111, 1'b1, 4'b0010, "sparse2");
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, "sparse_drain");

    // Stall holds the beat; the next beat loads on the cycle out_ready returns
    data_w[2] = 32'hDEAD_BEEF;
    applyStimulus(4'b0100, 4'b1111, 1'b1, 4'b0100, "stall_load");
    applyStimulus(4'b1111, 4'b1111, 1'b0, 4'b0000, "stall0");
    applyStimulus(4'b1111, 4'b1111, 1'b0, 4'b0000, "stall1");
    applyStimulus(4'b1111, 4'b1111, 1'b0, 4'b0000, "stall2");
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b1000, "stall_release");
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, "stall_drain");
    data_w[2] = 32'hA000_0002;

    // Channel 2 bursts while channel 0 competes
    applyStimulus(4'b0001, 4'b0001, 1'b1, 4'b0001, "burst_pre");
`ifdef ARB_MUX_LOCK_EN
    applyStimulus(4'b0101, 4'b0000, 1'b1, 4'b0100, "burst_b0");
    applyStimulus(4'b0101, 4'b0000, 1'b1, 4'b0100, "burst_b1");
    applyStimulus(4'b0101, 4'b0100, 1'b1, 4'b0100, "burst_b2");
    applyStimulus(4'b0001, 4'b0001, 1'b1, 4'b0001, "burst_after");
`else
    applyStimulus(4'b0101, 4'b0000, 1'b1, 4'b0100, "interleave0");
    applyStimulus(4'b0101, 4'b0000, 1'b1, 4'b0001, "interleave1");
    applyStimulus(4'b0101, 4'b0100, 1'b1, 4'b0100, "interleave2");
    applyStimulus(4'b0001, 4'b0001, 1'b1, 4'b0001, "interleave3");
`endif
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, "burst_drain");

    // Reset while a beat is held and a burst may be open; arbitration restarts at 0
    applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0100, "midreset_open");
    doReset("reset_mid");
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0001, "restart");
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, "restart_drain");

    // Fixed priority: channel 0 always wins, lower index beats higher
    use_fixed = 1'b1;
    doReset("reset_fixed");
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0001, "fixed0");
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0001, "fixed1");
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0001, "fixed2");
    applyStimulus(4'b1110, 4'b1111, 1'b1, 4'b0010, "fixed_no0");
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, "fixed_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
